// File: rtl/text_frame_ctrl_pkg.sv
// text_frame_ctrl_pkg: shared FSM states, overlay geometry constants, 640x480 timing and the origin step helper
package text_frame_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, HOLD} state_t;
  localparam int RESET_X = 296;
  localparam int RESET_Y = 224;
  localparam int X_STEP = 8;
  localparam int Y_STEP = 16;
  localparam int X_MAX = 600;
  localparam int Y_MAX = 464;
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int H_TOTAL = 800;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
  localparam int V_TOTAL = 525;
  function automatic logic [9:0] step_pos(input logic [9:0] pos, input logic dec, input logic inc,
                                          input int step, input int max);
    logic [10:0] p;
    p = {1'b0, pos};
    return (dec == inc) ? pos :
           dec ? ((p < 11'(step)) ? 10'(max) : 10'(p - 11'(step))) :
           ((p + 11'(step) > 11'(max)) ? 10'd0 : 10'(p + 11'(step)));
  endfunction
endpackage

// File: rtl/text_frame_ctrl_debounce_sync.sv
// debounce_sync: two-flop synchroniser followed by a stability counter
module debounce_sync #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync <= '0;
      cnt  <= '0;
      q    <= 1'b0;
    end else begin
      sync <= {sync[0], d};
      if (sync[1] == q) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        q   <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/text_frame_ctrl.sv
// text_frame_ctrl: debounced board controls committed to the text overlay once per vertical blank
module text_frame_ctrl
  import text_frame_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES   = 1000000,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vblank,
  input  logic [2:0] rgbswitches,
  input  logic       blink_sw,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [9:0] org_x,
  output logic [9:0] org_y,
  output logic [2:0] rgb_color,
  output logic       text_en,
  output logic       commit
);
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [7:0]    raw, db;
  logic [3:0]    btn_d, pend, press;
  logic          vb_d, phase, blink_wrap, new_phase;
  logic [BW-1:0] blink_cnt;
  logic [9:0]    nx, ny;
  state_t        state;
  assign raw = {blink_sw, rgbswitches, btn_down, btn_up, btn_right, btn_left};
  for (genvar i = 0; i < 8; i++) begin : g_deb
    debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk(clk), .reset(reset), .d(raw[i]), .q(db[i])
    );
  end
  assign press      = db[3:0] & ~btn_d;
  assign nx         = step_pos(org_x, pend[0], pend[1], X_STEP, X_MAX);
  assign ny         = step_pos(org_y, pend[2], pend[3], Y_STEP, Y_MAX);
  assign blink_wrap = blink_cnt == BW'(BLINK_FRAMES - 1);
  assign new_phase  = !db[7] ? 1'b1 : blink_wrap ? ~phase : phase;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      vb_d      <= 1'b0;
      btn_d     <= '0;
      pend      <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
      org_x     <= 10'(RESET_X);
      org_y     <= 10'(RESET_Y);
      rgb_color <= 3'b111;
      text_en   <= 1'b1;
      commit    <= 1'b0;
    end else begin
      vb_d   <= vblank;
      btn_d  <= db[3:0];
      commit <= 1'b0;
      pend   <= (state == APPLY) ? press : (pend | press);
      if (state == IDLE && vblank && !vb_d) state <= APPLY;
      else if (state == APPLY) begin
        state     <= HOLD;
        commit    <= 1'b1;
        rgb_color <= db[6:4];
        org_x     <= nx;
        org_y     <= ny;
        blink_cnt <= (!db[7] || blink_wrap) ? '0 : blink_cnt + 1'b1;
        phase     <= new_phase;
        text_en   <= new_phase;
      end else if (state == HOLD && !vblank) state <= IDLE;
    end
endmodule

// File: tb/tb_text_frame_ctrl.sv
// tb_text_frame_ctrl: directed checks of debouncing, frame-synchronous moves, wraps, blink and colour commit
module tb_text_frame_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vblank = 1'b0;
  logic [2:0] rgbswitches = 3'b111;
  logic       blink_sw = 1'b0;
  logic [3:0] btn = '0;
  logic [9:0] org_x, org_y;
  logic [2:0] rgb_color;
  logic       text_en, commit;
  int         checks = 0;
  int         errors = 0;
  text_frame_ctrl #(.DEB_CYCLES(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .vblank(vblank), .rgbswitches(rgbswitches), .blink_sw(blink_sw),
    .btn_left(btn[0]), .btn_right(btn[1]), .btn_up(btn[2]), .btn_down(btn[3]),
    .org_x(org_x), .org_y(org_y), .rgb_color(rgb_color), .text_en(text_en), .commit(commit)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input int idx);
    btn[idx] = 1'b1;
    wait_clks(10);
    btn[idx] = 1'b0;
    wait_clks(10);
  endtask
  task automatic frame();
    int pulses = 0;
    vblank = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pulses += int'(commit);
    end
    vblank = 1'b0;
    wait_clks(3);
    check("commit_pulses", pulses, 1);
  endtask
  initial begin
    logic [1:0] seq [6];
    seq = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
    wait_clks(3);
    check("rst_x", org_x, 296);
    check("rst_y", org_y, 224);
    check("rst_rgb", rgb_color, 3'b111);
    check("rst_en", text_en, 1);
    check("rst_commit", commit, 0);
    reset = 1'b1;
    wait_clks(10);
    press(1);
    check("x_before_vblank", org_x, 296);
    frame();
    check("x_right", org_x, 304);
    check("y_right", org_y, 224);
    #2 reset = 1'b0;
    #1;
    check("async_x", org_x, 296);
    check("async_y", org_y, 224);
    check("async_rgb", rgb_color, 3'b111);
    check("async_en", text_en, 1);
    @(negedge clk);
    reset = 1'b1;
    wait_clks(10);
    btn[1] = 1'b1; wait_clks(2);
    btn[1] = 1'b0; wait_clks(2);
    btn[1] = 1'b1; wait_clks(2);
    btn[1] = 1'b0; wait_clks(10);
    frame();
    check("x_bounce", org_x, 296);
    for (int i = 0; i < 37; i++) begin
      press(0);
      frame();
    end
    check("x_to_zero", org_x, 0);
    press(0);
    frame();
    check("x_wrap_left", org_x, 600);
    press(1);
    frame();
    check("x_wrap_right", org_x, 0);
    for (int i = 0; i < 14; i++) begin
      press(2);
      frame();
    end
    check("y_to_zero", org_y, 0);
    press(2);
    frame();
    check("y_wrap_up", org_y, 464);
    press(3);
    frame();
    check("y_wrap_down", org_y, 0);
    press(0);
    press(1);
    frame();
    check("x_left_right", org_x, 0);
    frame();
    check("x_flags_cleared", org_x, 0);
    btn[1] = 1'b1;
    wait_clks(5);
    vblank = 1'b1;
    wait_clks(4);
    vblank = 1'b0;
    wait_clks(3);
    check("x_apply_press", org_x, 0);
    btn[1] = 1'b0;
    wait_clks(10);
    frame();
    check("x_apply_next", org_x, 8);
    blink_sw = 1'b1;
    wait_clks(10);
    for (int i = 0; i < 6; i++) begin
      frame();
      check($sformatf("blink_%0d", i), text_en, seq[i]);
    end
    blink_sw = 1'b0;
    rgbswitches = 3'b101;
    wait_clks(10);
    check("rgb_before_vblank", rgb_color, 3'b111);
    frame();
    check("rgb_after", rgb_color, 3'b101);
    check("blink_off_en", text_en, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
